// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef logic [0:0] req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie, the requester not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            last,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            win
);

    always_comb begin
        gnt = '0;
        win = 1'b0;
        case (req)
            2'b01: begin
                gnt = 2'b01;
                win = 1'b0;
            end
            2'b10: begin
                gnt = 2'b10;
                win = 1'b1;
            end
            2'b11: begin
                if (last == 1'b1) begin
                    gnt = 2'b01;
                    win = 1'b0;
                end else begin
                    gnt = 2'b10;
                    win = 1'b1;
                end
            end
            default: begin
                gnt = '0;
                win = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one data-memory/IO port between the core LSU (m0) and a debug loader (m1).
// Writes complete in the grant cycle; a read blocks further grants until its data returns.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_m0_req,
    input  logic                i_m0_we,
    input  logic [ADDR_W-1:0]   i_m0_addr,
    input  logic [DATA_W-1:0]   i_m0_wdata,
    input  logic [DATA_W/8-1:0] i_m0_be,
    output logic                o_m0_gnt,
    output logic                o_m0_rvalid,
    output logic [DATA_W-1:0]   o_m0_rdata,
    input  logic                i_m1_req,
    input  logic                i_m1_we,
    input  logic [ADDR_W-1:0]   i_m1_addr,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_be,
    output logic                o_m1_gnt,
    output logic                o_m1_rvalid,
    output logic [DATA_W-1:0]   o_m1_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    localparam int                CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RD_LAT);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    req_id_t            owner;
    req_id_t            last;
    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] gnt_vec;
    req_id_t            win;
    logic               any_gnt;
    logic               rd_done;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == LAT_C) ? c : c + CNT_W'(1);
    endfunction

    // Reset gates requests so grants and the memory strobe drop immediately on assertion.
    assign req_vec = (state == IDLE && !i_reset) ? {i_m1_req, i_m0_req} : '0;

    rr_pick2 u_pick (
        .req  (req_vec),
        .last (last),
        .gnt  (gnt_vec),
        .win  (win)
    );

    assign any_gnt  = |gnt_vec;
    assign o_m0_gnt = gnt_vec[0];
    assign o_m1_gnt = gnt_vec[1];

    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        if (any_gnt) begin
            o_mem_req = 1'b1;
            if (win == 1'b1) begin
                o_mem_we    = i_m1_we;
                o_mem_addr  = i_m1_addr;
                o_mem_wdata = i_m1_wdata;
                o_mem_be    = i_m1_be;
            end else begin
                o_mem_we    = i_m0_we;
                o_mem_addr  = i_m0_addr;
                o_mem_wdata = i_m0_wdata;
                o_mem_be    = i_m0_be;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        last <= win;
                        if (!o_mem_we) begin
                            owner <= win;
                            state <= RD_WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_sat_inc(cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Read data is only forwarded in the single cycle the counter reaches the latency.
    assign rd_done     = (state == RD_WAIT) && (cnt == LAT_C);
    assign o_busy      = (state == RD_WAIT);
    assign o_m0_rvalid = rd_done && (owner == 1'b0);
    assign o_m1_rvalid = rd_done && (owner == 1'b1);
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses RD_LAT=2, instance b uses RD_LAT=1.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks;
    int   n_fail;

    always #5 clk = ~clk;

    logic          a_m0_req, a_m0_we, a_m0_gnt, a_m0_rvalid;
    logic [AW-1:0] a_m0_addr;
    logic [DW-1:0] a_m0_wdata, a_m0_rdata;
    logic [BW-1:0] a_m0_be;
    logic          a_m1_req, a_m1_we, a_m1_gnt, a_m1_rvalid;
    logic [AW-1:0] a_m1_addr;
    logic [DW-1:0] a_m1_wdata, a_m1_rdata;
    logic [BW-1:0] a_m1_be;
    logic          a_mem_req, a_mem_we, a_busy;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_wdata, a_mem_rdata;
    logic [BW-1:0] a_mem_be;

    logic          b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid;
    logic [AW-1:0] b_m0_addr;
    logic [DW-1:0] b_m0_wdata, b_m0_rdata;
    logic [BW-1:0] b_m0_be;
    logic          b_m1_req, b_m1_we, b_m1_gnt, b_m1_rvalid;
    logic [AW-1:0] b_m1_addr;
    logic [DW-1:0] b_m1_wdata, b_m1_rdata;
    logic [BW-1:0] b_m1_be;
    logic          b_mem_req, b_mem_we, b_busy;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata;
    logic [BW-1:0] b_mem_be;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut_a (
        .i_clk(clk), .i_reset(rst),
        .i_m0_req(a_m0_req), .i_m0_we(a_m0_we), .i_m0_addr(a_m0_addr),
        .i_m0_wdata(a_m0_wdata), .i_m0_be(a_m0_be),
        .o_m0_gnt(a_m0_gnt), .o_m0_rvalid(a_m0_rvalid), .o_m0_rdata(a_m0_rdata),
        .i_m1_req(a_m1_req), .i_m1_we(a_m1_we), .i_m1_addr(a_m1_addr),
        .i_m1_wdata(a_m1_wdata), .i_m1_be(a_m1_be),
        .o_m1_gnt(a_m1_gnt), .o_m1_rvalid(a_m1_rvalid), .o_m1_rdata(a_m1_rdata),
        .o_mem_req(a_mem_req), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .o_mem_be(a_mem_be),
        .i_mem_rdata(a_mem_rdata), .o_busy(a_busy)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_b (
        .i_clk(clk), .i_reset(rst),
        .i_m0_req(b_m0_req), .i_m0_we(b_m0_we), .i_m0_addr(b_m0_addr),
        .i_m0_wdata(b_m0_wdata), .i_m0_be(b_m0_be),
        .o_m0_gnt(b_m0_gnt), .o_m0_rvalid(b_m0_rvalid), .o_m0_rdata(b_m0_rdata),
        .i_m1_req(b_m1_req), .i_m1_we(b_m1_we), .i_m1_addr(b_m1_addr),
        .i_m1_wdata(b_m1_wdata), .i_m1_be(b_m1_be),
        .o_m1_gnt(b_m1_gnt), .o_m1_rvalid(b_m1_rvalid), .o_m1_rdata(b_m1_rdata),
        .o_mem_req(b_mem_req), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .o_mem_be(b_mem_be),
        .i_mem_rdata(b_mem_rdata), .o_busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drv_a0(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        a_m0_req = req; a_m0_we = we; a_m0_addr = addr; a_m0_wdata = wd; a_m0_be = 4'hF;
    endtask

    task automatic drv_a1(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        a_m1_req = req; a_m1_we = we; a_m1_addr = addr; a_m1_wdata = wd; a_m1_be = 4'h3;
    endtask

    task automatic drv_b0(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_m0_req = req; b_m0_we = we; b_m0_addr = addr; b_m0_wdata = wd; b_m0_be = 4'hF;
    endtask

    task automatic drv_b1(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_m1_req = req; b_m1_we = we; b_m1_addr = addr; b_m1_wdata = wd; b_m1_be = 4'hF;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drv_a0(1'b0, 1'b0, '0, '0);
        drv_a1(1'b0, 1'b0, '0, '0);
        drv_b0(1'b0, 1'b0, '0, '0);
        drv_b1(1'b0, 1'b0, '0, '0);
        a_mem_rdata = 32'hFFFF_FFFF;
        b_mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", 64'(a_mem_req), 64'(0));
        check("rst_busy",    64'(a_busy),    64'(0));
        check("rst_m0_rv",   64'(a_m0_rvalid), 64'(0));
        check("rst_m0_rd",   64'(a_m0_rdata),  64'(0));
        check("rst_m1_rd",   64'(a_m1_rdata),  64'(0));
        @(negedge clk);
        rst = 1'b0;
        a_mem_rdata = '0;
        @(negedge clk);
        #1;
        check("post_rst_mem_req", 64'(a_mem_req), 64'(0));
        check("post_rst_busy",    64'(a_busy),    64'(0));

        // Reset asserted mid-cycle forces outputs low without a clock edge
        @(negedge clk);
        drv_a0(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0055);
        #1;
        check("async_pre_gnt", 64'(a_m0_gnt), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("async_gnt",   64'(a_m0_gnt),    64'(0));
        check("async_req",   64'(a_mem_req),   64'(0));
        check("async_addr",  64'(a_mem_addr),  64'(0));
        check("async_wdata", 64'(a_mem_wdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        drv_a0(1'b0, 1'b0, '0, '0);

        // Single write, then back-to-back write
        @(negedge clk);
        drv_a0(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
        #1;
        check("wr_gnt",   64'(a_m0_gnt),    64'(1));
        check("wr_m1gnt", 64'(a_m1_gnt),    64'(0));
        check("wr_req",   64'(a_mem_req),   64'(1));
        check("wr_we",    64'(a_mem_we),    64'(1));
        check("wr_addr",  64'(a_mem_addr),  64'h2000);
        check("wr_wdata", 64'(a_mem_wdata), 64'hDEAD_BEEF);
        check("wr_be",    64'(a_mem_be),    64'hF);
        @(negedge clk);
        drv_a0(1'b1, 1'b1, 32'h0000_2004, 32'h0000_0001);
        #1;
        check("wr2_gnt",   64'(a_m0_gnt),    64'(1));
        check("wr2_addr",  64'(a_mem_addr),  64'h2004);
        check("wr2_wdata", 64'(a_mem_wdata), 64'h1);

        // Read latency and blocking (RD_LAT=2)
        @(negedge clk);
        drv_a0(1'b1, 1'b0, 32'h0000_3000, '0);
        #1;
        check("rd_gnt",  64'(a_m0_gnt),   64'(1));
        check("rd_we",   64'(a_mem_we),   64'(0));
        check("rd_addr", 64'(a_mem_addr), 64'h3000);
        @(negedge clk);
        drv_a0(1'b0, 1'b0, '0, '0);
        drv_a1(1'b1, 1'b1, 32'h0000_4000, 32'h0000_0077);
        #1;
        check("rd_t1_busy",  64'(a_busy),      64'(1));
        check("rd_t1_m1gnt", 64'(a_m1_gnt),    64'(0));
        check("rd_t1_req",   64'(a_mem_req),   64'(0));
        check("rd_t1_rv",    64'(a_m0_rvalid), 64'(0));
        @(negedge clk);
        a_mem_rdata = 32'h1234_5678;
        #1;
        check("rd_t2_rv",    64'(a_m0_rvalid), 64'(1));
        check("rd_t2_rdata", 64'(a_m0_rdata),  64'h1234_5678);
        check("rd_t2_m1rv",  64'(a_m1_rvalid), 64'(0));
        check("rd_t2_m1rd",  64'(a_m1_rdata),  64'(0));
        check("rd_t2_m1gnt", 64'(a_m1_gnt),    64'(0));
        check("rd_t2_busy",  64'(a_busy),      64'(1));
        @(negedge clk);
        a_mem_rdata = '0;
        #1;
        check("rd_t3_busy",  64'(a_busy),      64'(0));
        check("rd_t3_m1gnt", 64'(a_m1_gnt),    64'(1));
        check("rd_t3_rv",    64'(a_m0_rvalid), 64'(0));
        check("rd_t3_m1rv",  64'(a_m1_rvalid), 64'(0));
        check("rd_t3_addr",  64'(a_mem_addr),  64'h4000);

        // Fairness: both write continuously, then m1 alone
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv_a0(1'b1, 1'b1, 32'h0000_0100, 32'h0000_00A0);
            drv_a1(1'b1, 1'b1, 32'h0000_0200, 32'h0000_00B0);
            #1;
            check($sformatf("fair%0d_g0", i), 64'(a_m0_gnt), 64'((i % 2) == 0));
            check($sformatf("fair%0d_g1", i), 64'(a_m1_gnt), 64'((i % 2) == 1));
            check($sformatf("fair%0d_addr", i), 64'(a_mem_addr),
                  ((i % 2) == 0) ? 64'h100 : 64'h200);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drv_a0(1'b0, 1'b0, '0, '0);
            #1;
            check($sformatf("solo%0d_g1", i), 64'(a_m1_gnt), 64'(1));
            check($sformatf("solo%0d_g0", i), 64'(a_m0_gnt), 64'(0));
        end

        // Reset in the middle of an m1 read
        @(negedge clk);
        drv_a1(1'b1, 1'b0, 32'h0000_6000, '0);
        #1;
        check("rrst_gnt", 64'(a_m1_gnt), 64'(1));
        check("rrst_we",  64'(a_mem_we), 64'(0));
        @(negedge clk);
        drv_a1(1'b0, 1'b0, '0, '0);
        #1;
        check("rrst_t1_busy", 64'(a_busy), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("rrst_busy_async", 64'(a_busy), 64'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        a_mem_rdata = 32'hAAAA_AAAA;
        #1;
        check("rrst_t2_rv",   64'(a_m1_rvalid), 64'(0));
        check("rrst_t2_rd",   64'(a_m1_rdata),  64'(0));
        check("rrst_t2_busy", 64'(a_busy),      64'(0));
        @(negedge clk);
        a_mem_rdata = '0;
        drv_a0(1'b1, 1'b0, 32'h0000_5000, '0);
        #1;
        check("rrst_m0_gnt", 64'(a_m0_gnt), 64'(1));
        check("rrst_m1_gnt", 64'(a_m1_gnt), 64'(0));
        @(negedge clk);
        drv_a0(1'b0, 1'b0, '0, '0);
        #1;
        check("rrst_m0_busy", 64'(a_busy), 64'(1));
        @(negedge clk);
        a_mem_rdata = 32'hCAFE_F00D;
        #1;
        check("rrst_m0_rv", 64'(a_m0_rvalid), 64'(1));
        check("rrst_m0_rd", 64'(a_m0_rdata),  64'hCAFE_F00D);
        @(negedge clk);
        a_mem_rdata = '0;
        #1;
        check("rrst_end_busy", 64'(a_busy), 64'(0));

        // RD_LAT=1: alternating reads, grants every second cycle
        @(negedge clk);
        drv_b0(1'b1, 1'b0, 32'h0000_00A0, '0);
        drv_b1(1'b1, 1'b0, 32'h0000_00B0, '0);
        #1;
        check("l1_t0_g0",   64'(b_m0_gnt),   64'(1));
        check("l1_t0_g1",   64'(b_m1_gnt),   64'(0));
        check("l1_t0_addr", 64'(b_mem_addr), 64'hA0);
        @(negedge clk);
        drv_b0(1'b0, 1'b0, '0, '0);
        b_mem_rdata = 32'h1111_0000;
        #1;
        check("l1_t1_rv0",  64'(b_m0_rvalid), 64'(1));
        check("l1_t1_rd0",  64'(b_m0_rdata),  64'h1111_0000);
        check("l1_t1_rv1",  64'(b_m1_rvalid), 64'(0));
        check("l1_t1_g1",   64'(b_m1_gnt),    64'(0));
        check("l1_t1_busy", 64'(b_busy),      64'(1));
        @(negedge clk);
        b_mem_rdata = '0;
        drv_b0(1'b1, 1'b0, 32'h0000_00A4, '0);
        #1;
        check("l1_t2_g1",   64'(b_m1_gnt),    64'(1));
        check("l1_t2_g0",   64'(b_m0_gnt),    64'(0));
        check("l1_t2_addr", 64'(b_mem_addr),  64'hB0);
        check("l1_t2_rv0",  64'(b_m0_rvalid), 64'(0));
        @(negedge clk);
        drv_b1(1'b0, 1'b0, '0, '0);
        b_mem_rdata = 32'h2222_0001;
        #1;
        check("l1_t3_rv1", 64'(b_m1_rvalid), 64'(1));
        check("l1_t3_rd1", 64'(b_m1_rdata),  64'h2222_0001);
        check("l1_t3_rv0", 64'(b_m0_rvalid), 64'(0));
        check("l1_t3_g0",  64'(b_m0_gnt),    64'(0));
        @(negedge clk);
        b_mem_rdata = '0;
        #1;
        check("l1_t4_g0",   64'(b_m0_gnt),   64'(1));
        check("l1_t4_addr", 64'(b_mem_addr), 64'hA4);
        @(negedge clk);
        drv_b0(1'b0, 1'b0, '0, '0);
        b_mem_rdata = 32'h3333_0002;
        #1;
        check("l1_t5_rv0", 64'(b_m0_rvalid), 64'(1));
        check("l1_t5_rd0", 64'(b_m0_rdata),  64'h3333_0002);
        check("l1_t5_rv1", 64'(b_m1_rvalid), 64'(0));
        @(negedge clk);
        b_mem_rdata = '0;
        #1;
        check("l1_t6_busy", 64'(b_busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared data-memory / IO bus port between two requesters.
- Requester 0 is the core LSU path. Requester 1 is a debug/program loader.
- Round-robin on contention; one read outstanding at a time.
- Sits between the requesters and the data memory/IO bus. The core stalls on its request until granted.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8)
RD_LAT, 1, memory read latency in cycles from grant cycle to valid i_mem_rdata; legal range 1..4

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_m0_req  in  1  requester 0 transaction request
i_m0_we  in  1  requester 0: 1 = write, 0 = read
i_m0_addr  in  ADDR_W  requester 0 address
i_m0_wdata  in  DATA_W  requester 0 write data
i_m0_be  in  DATA_W/8  requester 0 byte enables
o_m0_gnt  out  1  requester 0 request accepted this cycle
o_m0_rvalid  out  1  requester 0 read data valid
o_m0_rdata  out  DATA_W  requester 0 read data
i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_be, o_m1_gnt, o_m1_rvalid, o_m1_rdata  same as m0, for requester 1
o_mem_req  out  1  memory access strobe
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
o_mem_be  out  DATA_W/8  memory byte enables
i_mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the o_mem_req cycle
o_busy  out  1  read in flight

Behaviour:
- Reset: async, active-high.
  - All outputs are 0 during reset; rdata outputs are 0.
  - State = IDLE, latency counter = 0, last-grant pointer = 1, so m0 wins the first tie.
- FSM has two states: IDLE and RD_WAIT.
- Requester protocol:
  - A requester holds req and all its fields stable until gnt.
  - Dropping req before gnt is legal; no transaction occurs.
  - gnt is combinational from req and state, with no req-to-gnt register delay.
- IDLE arbitration:
  - Only one requester active: grant it.
  - Both active: grant the one not granted last.
  - On the grant cycle: o_mem_req = 1 and o_mem_* = winner's fields (combinational mux); update last-grant pointer; o_mX_gnt = 1 for the winner only.
  - o_mem_* fields are 0 when there is no grant.
- Write grant: completes in the grant cycle. FSM stays IDLE, so a new grant is possible the next cycle (back-to-back writes at full rate).
- Read grant in cycle T:
  - Register owner id; FSM goes to RD_WAIT at T+1; counter loads 1.
  - RD_WAIT occupies cycles T+1..T+RD_LAT; counter increments each cycle.
  - In cycle T+RD_LAT (counter == RD_LAT): o_mX_rvalid = 1 for the owner only, for exactly one cycle, and o_mX_rdata = i_mem_rdata. FSM returns to IDLE at T+RD_LAT+1.
  - Earliest next grant is T+RD_LAT+1. No gnt to either requester while in RD_WAIT.
- o_busy = 1 exactly while in RD_WAIT.
- Non-owner rvalid is always 0. Non-owner rdata is 0.
- Reset mid-read: FSM to IDLE, the pending rvalid is never produced, and the late memory data is ignored.
- Counter width is clog2(RD_LAT+1). It must not wrap; it saturates at RD_LAT.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, RD_WAIT}
  - req_id_t (1 bit)
  - localparam NUM_REQ = 2
- Sub-module rr_pick2: combinational two-way round-robin picker. Inputs: req vector and last pointer. Outputs: one-hot grant and winner id.
- FSM, counter and muxes stay in mem_arbiter.

Test Plan (RD_LAT=2 unless noted):
- Reset behaviour: assert i_reset mid-cycle -> all outputs 0 asynchronously. After release with no req -> o_mem_req = 0, o_busy = 0.
- Single write: m0 write, addr 0x0000_2000, wdata 0xDEAD_BEEF, be 4'hF -> same cycle: o_m0_gnt = 1, o_mem_req = 1, o_mem_we = 1, o_mem_addr = 0x2000, o_mem_wdata = 0xDEAD_BEEF. Next cycle: second m0 write granted immediately.
- Read latency and blocking: m0 read granted at T; m1 req held from T+1; i_mem_rdata = 0x1234_5678 at T+2 -> o_m0_rvalid = 1 only at T+2 with rdata 0x1234_5678; o_busy = 1 at T+1..T+2; o_m1_gnt = 0 until T+3; o_m1_rvalid never asserts.
- Fairness: m0 and m1 both request writes continuously for 4 cycles -> grant order m0, m1, m0, m1. Then m1 alone for 2 cycles -> m1, m1.
- Reset mid-read: m1 read granted at T, i_reset pulsed at T+1 -> no o_m1_rvalid at T+2; o_busy = 0 after reset; m0 read after release granted on its first request cycle.
- RD_LAT=1 sweep: alternating m0/m1 reads -> grants at T, T+2, T+4; each rvalid one cycle after its grant to the correct owner.
